// File: rtl/t08_mmio_pkg.sv
// Shared types for the MMIO controller: FSM states, decode targets and the error read-back word.
package t08_mmio_pkg;

    typedef enum logic [2:0] {IDLE, MEM_REQ, MEM_WAIT, PERIPH, RESP} state_e;
    typedef enum logic [1:0] {TGT_MEM, TGT_PER, TGT_ERR} tgt_e;

    localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

endpackage

// File: rtl/t08_mmio_decode.sv
// Combinational address decode: memory window, single-address peripheral slots, or unmapped.
module t08_mmio_decode
    import t08_mmio_pkg::*;
#(
    parameter int                       AW          = 32,
    parameter int                       MEM_DEPTH   = 2048,
    parameter int                       NUM_PERIPH  = 3,
    parameter logic [NUM_PERIPH*AW-1:0] PERIPH_BASE = {AW'(923923), AW'(333333), AW'(121212)}
) (
    input  logic [AW-1:0]         i_addr,
    output tgt_e                  o_tgt,
    output logic [NUM_PERIPH-1:0] o_slot
);

    localparam logic [AW-1:0] MEM_LIM = AW'(MEM_DEPTH);

    logic w_hit;

    // Scan from the top slot down so the lowest matching slot is the one left standing.
    always_comb begin
        o_slot = '0;
        w_hit  = 1'b0;
        for (int k = NUM_PERIPH - 1; k >= 0; k--) begin
            if (i_addr == PERIPH_BASE[k*AW +: AW]) begin
                o_slot    = '0;
                o_slot[k] = 1'b1;
                w_hit     = 1'b1;
            end
        end
        if (i_addr < MEM_LIM)
            o_tgt = TGT_MEM;
        else if (w_hit)
            o_tgt = TGT_PER;
        else
            o_tgt = TGT_ERR;
    end

endmodule

// File: rtl/t08_mmio_ctrl.sv
// Registered MMIO controller: routes one handler access to memory or a peripheral slot,
// with per-access timeout and error reporting.
module t08_mmio_ctrl
    import t08_mmio_pkg::*;
#(
    parameter int                       DW          = 32,
    parameter int                       AW          = 32,
    parameter int                       MEM_DEPTH   = 2048,
    parameter int                       NUM_PERIPH  = 3,
    parameter logic [NUM_PERIPH*AW-1:0] PERIPH_BASE = {AW'(923923), AW'(333333), AW'(121212)},
    parameter int                       TIMEOUT     = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mh_read_i,
    input  logic                     mh_write_i,
    input  logic [AW-1:0]            mh_addr_i,
    input  logic [DW-1:0]            mh_wdata_i,
    output logic [DW-1:0]            mh_rdata_o,
    output logic                     mh_busy_o,
    output logic                     mh_done_o,
    output logic                     mh_err_o,
    output logic                     mem_read_o,
    output logic                     mem_write_o,
    output logic [AW-1:0]            mem_addr_o,
    output logic [DW-1:0]            mem_wdata_o,
    output logic [3:0]               mem_sel_o,
    input  logic [DW-1:0]            mem_rdata_i,
    input  logic                     mem_busy_i,
    output logic [NUM_PERIPH-1:0]    per_sel_o,
    output logic                     per_read_o,
    output logic                     per_write_o,
    output logic [DW-1:0]            per_wdata_o,
    input  logic [NUM_PERIPH*DW-1:0] per_rdata_i,
    input  logic [NUM_PERIPH-1:0]    per_ready_i
);

    localparam int             CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  CNT_MAX  = '1;
    localparam logic [CW-1:0]  TMO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [DW-1:0]  ERR_DW   = DW'(ERR_WORD);

    state_e                r_state, w_next;
    logic [AW-1:0]         r_addr;
    logic [DW-1:0]         r_wdata, r_rdata, w_rdata_nxt, w_prd;
    logic                  r_rd, r_wr, r_err;
    logic [NUM_PERIPH-1:0] r_sel, w_slot;
    logic [CW-1:0]         r_cnt;
    tgt_e                  w_tgt;
    logic                  w_req, w_accept, w_cnt_en, w_tmo, w_rdy;
    logic                  w_mem_stb, w_per_stb, w_resp, w_err_nxt, w_ld;

    t08_mmio_decode #(
        .AW          (AW),
        .MEM_DEPTH   (MEM_DEPTH),
        .NUM_PERIPH  (NUM_PERIPH),
        .PERIPH_BASE (PERIPH_BASE)
    ) u_decode (
        .i_addr (mh_addr_i),
        .o_tgt  (w_tgt),
        .o_slot (w_slot)
    );

    assign w_req    = mh_read_i | mh_write_i;
    assign w_accept = (r_state == IDLE) && w_req;
    assign w_cnt_en = (r_state == MEM_REQ) || (r_state == MEM_WAIT) || (r_state == PERIPH);
    assign w_tmo    = (TIMEOUT != 0) && (r_cnt == TMO_LAST);
    assign w_rdy    = |(per_ready_i & r_sel);

    always_comb begin
        w_prd = '0;
        for (int k = 0; k < NUM_PERIPH; k++)
            if (r_sel[k]) w_prd = per_rdata_i[k*DW +: DW];
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // A real completion in the same cycle as the timeout wins: the target already saw the strobe.
    always_comb begin
        w_next      = r_state;
        w_mem_stb   = 1'b0;
        w_per_stb   = 1'b0;
        w_resp      = 1'b0;
        w_err_nxt   = 1'b0;
        w_ld        = 1'b0;
        w_rdata_nxt = r_rdata;
        unique case (r_state)
            IDLE: begin
                if (w_req) begin
                    if ((mh_read_i && mh_write_i) || (w_tgt == TGT_ERR)) begin
                        w_next      = RESP;
                        w_resp      = 1'b1;
                        w_err_nxt   = 1'b1;
                        w_ld        = 1'b1;
                        w_rdata_nxt = ERR_DW;
                    end else if (w_tgt == TGT_MEM) begin
                        w_next = MEM_REQ;
                    end else begin
                        w_next = PERIPH;
                    end
                end
            end
            MEM_REQ: begin
                w_mem_stb = 1'b1;
                if (w_tmo) begin
                    w_next      = RESP;
                    w_resp      = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_ld        = 1'b1;
                    w_rdata_nxt = ERR_DW;
                end else if (mem_busy_i) begin
                    w_next = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (!mem_busy_i) begin
                    w_next      = RESP;
                    w_resp      = 1'b1;
                    w_ld        = r_rd;
                    w_rdata_nxt = mem_rdata_i;
                end else if (w_tmo) begin
                    w_next      = RESP;
                    w_resp      = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_ld        = 1'b1;
                    w_rdata_nxt = ERR_DW;
                end
            end
            PERIPH: begin
                if (w_rdy) begin
                    w_per_stb   = 1'b1;
                    w_next      = RESP;
                    w_resp      = 1'b1;
                    w_ld        = r_rd;
                    w_rdata_nxt = w_prd;
                end else if (w_tmo) begin
                    w_next      = RESP;
                    w_resp      = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_ld        = 1'b1;
                    w_rdata_nxt = ERR_DW;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_sel   <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= mh_addr_i;
                r_wdata <= mh_wdata_i;
                r_rd    <= mh_read_i;
                r_wr    <= mh_write_i;
                r_sel   <= w_slot;
                r_cnt   <= '0;
            end else if (w_cnt_en && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_ld)   r_rdata <= w_rdata_nxt;
            if (w_resp) r_err   <= w_err_nxt;
        end
    end

    assign mh_rdata_o  = r_rdata;
    assign mh_done_o   = (r_state == RESP);
    assign mh_err_o    = mh_done_o & r_err;
    assign mh_busy_o   = (r_state != IDLE) && (r_state != RESP);
    assign mem_read_o  = w_mem_stb & r_rd;
    assign mem_write_o = w_mem_stb & r_wr;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign mem_sel_o   = 4'b1111;
    assign per_sel_o   = w_per_stb ? r_sel : '0;
    assign per_read_o  = w_per_stb & r_rd;
    assign per_write_o = w_per_stb & r_wr;
    assign per_wdata_o = r_wdata;

endmodule

// File: tb/tb_t08_mmio_ctrl.sv
// Directed, table-driven bench for t08_mmio_ctrl with TIMEOUT=8 and default address map.
module tb_t08_mmio_ctrl;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NP = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             mh_read_i, mh_write_i;
    logic [AW-1:0]    mh_addr_i;
    logic [DW-1:0]    mh_wdata_i, mh_rdata_o;
    logic             mh_busy_o, mh_done_o, mh_err_o;
    logic             mem_read_o, mem_write_o;
    logic [AW-1:0]    mem_addr_o;
    logic [DW-1:0]    mem_wdata_o, mem_rdata_i;
    logic [3:0]       mem_sel_o;
    logic             mem_busy_i;
    logic [NP-1:0]    per_sel_o;
    logic             per_read_o, per_write_o;
    logic [DW-1:0]    per_wdata_o;
    logic [NP*DW-1:0] per_rdata_i;
    logic [NP-1:0]    per_ready_i;

    always #5 clk = ~clk;

    t08_mmio_ctrl #(
        .DW(DW), .AW(AW), .MEM_DEPTH(2048), .NUM_PERIPH(NP),
        .PERIPH_BASE({32'd923923, 32'd333333, 32'd121212}), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .mh_read_i(mh_read_i), .mh_write_i(mh_write_i), .mh_addr_i(mh_addr_i), .mh_wdata_i(mh_wdata_i),
        .mh_rdata_o(mh_rdata_o), .mh_busy_o(mh_busy_o), .mh_done_o(mh_done_o), .mh_err_o(mh_err_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_sel_o(mem_sel_o), .mem_rdata_i(mem_rdata_i), .mem_busy_i(mem_busy_i),
        .per_sel_o(per_sel_o), .per_read_o(per_read_o), .per_write_o(per_write_o),
        .per_wdata_o(per_wdata_o), .per_rdata_i(per_rdata_i), .per_ready_i(per_ready_i)
    );

    // One access: request, environment behaviour, and expected handler-visible result.
    // Cycle 1 is the IDLE cycle in which the request is first presented.
    typedef struct {
        logic        rd, wr;
        logic [31:0] addr, wdata, mrdata;
        int          bs, be;      // mem_busy_i high in cycles [bs, be]
        int          tslot, rlow; // per_ready_i[tslot] low in cycles 1..rlow
        int          lat;         // cycle index in which mh_done_o is high
        logic        err;
        logic [31:0] rdata;
        int          mrd, mwr, prd, pwr;
        logic [2:0]  psel;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] mrdata, input int bs, input int be, input int tslot, input int rlow,
                       input int lat, input logic err, input logic [31:0] rdata,
                       input int mrd, input int mwr, input int prd, input int pwr, input logic [2:0] psel);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.mrdata = mrdata;
        v.bs = bs; v.be = be; v.tslot = tslot; v.rlow = rlow;
        v.lat = lat; v.err = err; v.rdata = rdata;
        v.mrd = mrd; v.mwr = mwr; v.prd = prd; v.pwr = pwr; v.psel = psel;
        tbl.push_back(v);
    endtask

    // Called at a falling edge; returns at the falling edge after the done cycle with requests dropped.
    task automatic run_vec(input int idx);
        vec_t        v;
        int          lat, mrd, mwr, prd, pwr, pselc, bad_data;
        logic [2:0]  psel;
        logic        err, busy2;
        logic [31:0] rdata;
        v = tbl[idx];
        lat = 0; mrd = 0; mwr = 0; prd = 0; pwr = 0; pselc = 0; bad_data = 0;
        psel = '0; err = 1'b0; busy2 = 1'b0; rdata = '0;
        mh_read_i   = v.rd;
        mh_write_i  = v.wr;
        mh_addr_i   = v.addr;
        mh_wdata_i  = v.wdata;
        mem_rdata_i = v.mrdata;
        for (int cyc = 1; cyc <= 40 && lat == 0; cyc++) begin
            mem_busy_i  = (cyc >= v.bs) && (cyc <= v.be);
            per_ready_i = '1;
            if (v.tslot >= 0 && cyc <= v.rlow) per_ready_i[v.tslot] = 1'b0;
            #1;
            if (mem_read_o)  mrd++;
            if (mem_write_o) mwr++;
            if (per_read_o)  prd++;
            if (per_write_o) pwr++;
            if (per_sel_o != '0) begin
                pselc++;
                psel = psel | per_sel_o;
            end
            if ((mem_read_o || mem_write_o) && mem_addr_o !== v.addr) bad_data++;
            if (mem_write_o && mem_wdata_o !== v.wdata) bad_data++;
            if (per_write_o && per_wdata_o !== v.wdata) bad_data++;
            if (cyc == 2) busy2 = mh_busy_o;
            if (mh_done_o) begin
                lat   = cyc;
                err   = mh_err_o;
                rdata = mh_rdata_o;
            end
            @(negedge clk);
        end
        mh_read_i   = 1'b0;
        mh_write_i  = 1'b0;
        mem_busy_i  = 1'b0;
        per_ready_i = '1;
        chk($sformatf("v%0d latency", idx), lat, v.lat);
        chk($sformatf("v%0d err", idx), 32'(err), 32'(v.err));
        chk($sformatf("v%0d rdata", idx), rdata, v.rdata);
        chk($sformatf("v%0d mem_read cycles", idx), mrd, v.mrd);
        chk($sformatf("v%0d mem_write cycles", idx), mwr, v.mwr);
        chk($sformatf("v%0d per_read cycles", idx), prd, v.prd);
        chk($sformatf("v%0d per_write cycles", idx), pwr, v.pwr);
        chk($sformatf("v%0d per_sel", idx), 32'(psel), 32'(v.psel));
        chk($sformatf("v%0d per_sel cycles", idx), pselc, v.prd + v.pwr);
        chk($sformatf("v%0d strobe addr/data", idx), bad_data, 0);
        if (v.lat > 2) chk($sformatf("v%0d busy", idx), 32'(busy2), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dn;
        //  rd wr addr          wdata         mrdata        bs be  ts rl  lat err rdata         mrd mwr prd pwr psel
        add(1, 0, 32'h10,       32'h0,        32'hCAFE0001, 2, 4, -1, 0,  6, 0, 32'hCAFE0001, 1, 0, 0, 0, 3'b000);
        add(0, 1, 32'd121212,   32'h12345678, 32'h0,        0, 0,  0, 5,  7, 0, 32'hCAFE0001, 0, 0, 0, 1, 3'b001);
        add(1, 0, 32'd923923,   32'h0,        32'h0,        0, 0,  2, 0,  3, 0, 32'h00AB00CD, 0, 0, 1, 0, 3'b100);
        add(1, 0, 32'd5000,     32'h0,        32'h0,        0, 0, -1, 0,  2, 1, 32'hDEADBEEF, 0, 0, 0, 0, 3'b000);
        add(0, 1, 32'h7FF,      32'hA5A5A5A5, 32'h0,        2, 2, -1, 0,  4, 0, 32'hDEADBEEF, 0, 1, 0, 0, 3'b000);
        add(1, 0, 32'd2048,     32'h0,        32'h0,        0, 0, -1, 0,  2, 1, 32'hDEADBEEF, 0, 0, 0, 0, 3'b000);
        add(1, 0, 32'd333333,   32'h0,        32'h0,        0, 0,  1, 0,  3, 0, 32'h22220001, 0, 0, 1, 0, 3'b010);
        add(0, 1, 32'd333333,   32'h0BADF00D, 32'h0,        0, 0,  1, 0,  3, 0, 32'h22220001, 0, 0, 0, 1, 3'b010);
        add(1, 1, 32'h10,       32'h0,        32'h0,        0, 0, -1, 0,  2, 1, 32'hDEADBEEF, 0, 0, 0, 0, 3'b000);
        add(1, 0, 32'h0,        32'h0,        32'h13579BDF, 3, 3, -1, 0,  5, 0, 32'h13579BDF, 2, 0, 0, 0, 3'b000);
        add(1, 0, 32'h20,       32'h0,        32'h0,        2, 99,-1, 0, 10, 1, 32'hDEADBEEF, 1, 0, 0, 0, 3'b000);
        add(1, 0, 32'd121212,   32'h0,        32'h0,        0, 0,  0, 99,10, 1, 32'hDEADBEEF, 0, 0, 0, 0, 3'b000);
        add(1, 0, 32'h30,       32'h0,        32'h00001234, 2, 2, -1, 0,  4, 0, 32'h00001234, 1, 0, 0, 0, 3'b000);
        add(1, 0, 32'h40,       32'h0,        32'h0,        0, 0, -1, 0, 10, 1, 32'hDEADBEEF, 8, 0, 0, 0, 3'b000);
        add(1, 0, 32'h60,       32'h0,        32'h0000BEEF, 2, 2, -1, 0,  4, 0, 32'h0000BEEF, 1, 0, 0, 0, 3'b000);

        // Reset held with a request pending: nothing may start.
        mh_read_i   = 1'b1;
        mh_write_i  = 1'b0;
        mh_addr_i   = 32'h10;
        mh_wdata_i  = '0;
        mem_rdata_i = '0;
        mem_busy_i  = 1'b0;
        per_ready_i = '1;
        per_rdata_i = {32'h00AB00CD, 32'h22220001, 32'h11110000};
        repeat (2) @(negedge clk);
        #1;
        chk("rst busy", 32'(mh_busy_o), 0);
        chk("rst done/err", 32'({mh_done_o, mh_err_o}), 0);
        chk("rst strobes", 32'({mem_read_o, mem_write_o, per_read_o, per_write_o, per_sel_o}), 0);
        chk("rst rdata", mh_rdata_o, 0);
        chk("rst mem_addr", mem_addr_o, 0);
        chk("rst wdata", mem_wdata_o | per_wdata_o, 0);
        chk("mem_sel", 32'(mem_sel_o), 32'hF);
        @(negedge clk);
        mh_read_i = 1'b0;
        rst       = 1'b0;

        for (int i = 0; i < 14; i++) run_vec(i);

        // Reset while in MEM_WAIT: access abandoned without a done pulse.
        mh_read_i = 1'b1;
        mh_addr_i = 32'h50;
        @(negedge clk);
        mem_busy_i = 1'b1;
        @(negedge clk);
        #1;
        chk("mr wait busy", 32'(mh_busy_o), 1);
        chk("mr wait strobe", 32'(mem_read_o), 0);
        rst       = 1'b1;
        mh_read_i = 1'b0;
        @(negedge clk);
        #1;
        chk("mr busy", 32'(mh_busy_o), 0);
        chk("mr done", 32'(mh_done_o), 0);
        chk("mr strobe", 32'(mem_read_o), 0);
        chk("mr rdata", mh_rdata_o, 0);
        chk("mr mem_addr", mem_addr_o, 0);
        rst        = 1'b0;
        mem_busy_i = 1'b0;
        dn = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            if (mh_done_o || mh_busy_o) dn++;
        end
        chk("mr quiet after reset", dn, 0);
        @(negedge clk);
        run_vec(14);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
